// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite transfer encodings and default-slave state type.
`default_nettype none

package ahb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } defslv_state_t;

endpackage

`default_nettype wire

// File: rtl/ahb_err_logger.sv
// ahb_err_logger: captures the last erroring transfer, counts errors (saturating), sticky irq.
`default_nettype none

module ahb_err_logger #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  accept_i,
    input  logic                  clr_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  write_i,
    output logic [ADDR_WIDTH-1:0] err_addr_o,
    output logic                  err_write_o,
    output logic [CNT_WIDTH-1:0]  err_cnt_o,
    output logic                  err_irq_o
);

    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_irq;

    // An accept coinciding with a clear restarts the count at one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_cnt   <= '0;
            r_irq   <= 1'b0;
        end else if (accept_i) begin
            r_addr  <= addr_i;
            r_write <= write_i;
            r_irq   <= 1'b1;
            if (clr_i)
                r_cnt <= C_CNT_ONE;
            else if (r_cnt != C_CNT_MAX)
                r_cnt <= r_cnt + C_CNT_ONE;
        end else if (clr_i) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_cnt   <= '0;
            r_irq   <= 1'b0;
        end
    end

    assign err_addr_o  = r_addr;
    assign err_write_o = r_write;
    assign err_cnt_o   = r_cnt;
    assign err_irq_o   = r_irq;

endmodule

`default_nettype wire

// File: rtl/ahb_default_slave.sv
// ahb_default_slave: AHB-Lite default responder, two-cycle ERROR for unclaimed transfers.
// Optional error log/counter/irq enabled by defining AHB_DEFSLV_LOG_EN.
`default_nettype none

module ahb_default_slave
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  hsel_i,
    input  logic [ADDR_WIDTH-1:0] haddr_i,
    input  logic [1:0]            htrans_i,
    input  logic                  hwrite_i,
    input  logic                  hready_i,
    output logic                  hreadyout_o,
    output logic                  hresp_o,
    input  logic                  err_clr_i,
    output logic [ADDR_WIDTH-1:0] err_addr_o,
    output logic                  err_write_o,
    output logic [CNT_WIDTH-1:0]  err_cnt_o,
    output logic                  err_irq_o
);

    defslv_state_t r_state;
    defslv_state_t w_next;
    logic          w_accept;
    logic          r_hreadyout;
    logic          r_hresp;

    // ERR1 stalls the bus, so any address phase seen then is not a real one.
    assign w_accept = hsel_i & hready_i & htrans_i[1] & (r_state != DS_ERR1);

    always_comb begin
        w_next = DS_IDLE;
        case (r_state)
            DS_IDLE: w_next = w_accept ? DS_ERR1 : DS_IDLE;
            DS_ERR1: w_next = DS_ERR2;
            DS_ERR2: w_next = w_accept ? DS_ERR1 : DS_IDLE;
            default: w_next = DS_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= DS_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
        end else begin
            r_state     <= w_next;
            r_hreadyout <= (w_next != DS_ERR1);
            r_hresp     <= (w_next == DS_IDLE) ? HRESP_OKAY : HRESP_ERROR;
        end
    end

    assign hreadyout_o = r_hreadyout;
    assign hresp_o     = r_hresp;

`ifdef AHB_DEFSLV_LOG_EN
    ahb_err_logger #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_err_logger (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .accept_i    (w_accept),
        .clr_i       (err_clr_i),
        .addr_i      (haddr_i),
        .write_i     (hwrite_i),
        .err_addr_o  (err_addr_o),
        .err_write_o (err_write_o),
        .err_cnt_o   (err_cnt_o),
        .err_irq_o   (err_irq_o)
    );
`else
    logic w_unused_log;
    assign w_unused_log = &{1'b0, err_clr_i, haddr_i, hwrite_i};

    assign err_addr_o  = '0;
    assign err_write_o = 1'b0;
    assign err_cnt_o   = '0;
    assign err_irq_o   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ahb_default_slave.sv
// tb_ahb_default_slave: randomized and directed checks of ahb_default_slave against a cycle-indexed model.
`default_nettype none

module tb_ahb_default_slave;
    import ahb_pkg::*;

    localparam int AW = 32;
    localparam int CW = 2;
    localparam int CNT_MAX = (1 << CW) - 1;
`ifdef AHB_DEFSLV_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          hsel;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic          hready;
    logic          hreadyout;
    logic          hresp;
    logic          err_clr;
    logic [AW-1:0] err_addr;
    logic          err_write;
    logic [CW-1:0] err_cnt;
    logic          err_irq;

    int vectors = 0;
    int miscompares = 0;

    ahb_default_slave #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .hsel_i      (hsel),
        .haddr_i     (haddr),
        .htrans_i    (htrans),
        .hwrite_i    (hwrite),
        .hready_i    (hready),
        .hreadyout_o (hreadyout),
        .hresp_o     (hresp),
        .err_clr_i   (err_clr),
        .err_addr_o  (err_addr),
        .err_write_o (err_write),
        .err_cnt_o   (err_cnt),
        .err_irq_o   (err_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: an accept in cycle c makes cycle c+1 the stalled ERROR cycle and c+2 the final one.
    int          cyc_n = 0;
    int          err_at = -100;
    logic [31:0] m_addr = '0;
    logic        m_write = 1'b0;
    int          m_cnt = 0;
    logic        m_irq = 1'b0;

    always @(negedge clk) begin
        cyc_n++;
        if (rst) begin
            err_at  = -100;
            m_addr  = '0;
            m_write = 1'b0;
            m_cnt   = 0;
            m_irq   = 1'b0;
        end
        chk("m_hreadyout", hreadyout, (cyc_n == err_at) ? 0 : 1);
        chk("m_hresp", hresp, (cyc_n == err_at || cyc_n == err_at + 1) ? 1 : 0);
        chk("m_err_addr", err_addr, LOG_EN ? m_addr : 0);
        chk("m_err_write", err_write, LOG_EN ? m_write : 0);
        chk("m_err_cnt", err_cnt, LOG_EN ? m_cnt : 0);
        chk("m_err_irq", err_irq, LOG_EN ? m_irq : 0);
        if (!rst) begin
            if (hsel && hready && htrans[1] && cyc_n != err_at) begin
                err_at  = cyc_n + 1;
                m_addr  = haddr;
                m_write = hwrite;
                m_cnt   = err_clr ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX);
                m_irq   = 1'b1;
            end else if (err_clr) begin
                m_addr  = '0;
                m_write = 1'b0;
                m_cnt   = 0;
                m_irq   = 1'b0;
            end
        end
    end

    task automatic drive(input logic s, input logic [31:0] a, input logic [1:0] t,
                         input logic w, input logic r, input logic c);
        @(posedge clk);
        #1;
        hsel = s; haddr = a; htrans = t; hwrite = w; hready = r; err_clr = c;
    endtask

    task automatic idle(input logic r);
        drive(1'b0, 32'h0, HT_IDLE, 1'b0, r, 1'b0);
    endtask

    task automatic bus(input string name, input logic ro, input logic rs);
        chk({name, "_hreadyout"}, hreadyout, ro);
        chk({name, "_hresp"}, hresp, rs);
    endtask

    initial begin
        rst = 1'b1;
        hsel = 1'b0; haddr = '0; htrans = HT_IDLE; hwrite = 1'b0; hready = 1'b1; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bus("reset", 1'b1, 1'b0);
        chk("reset_cnt", err_cnt, 0);
        chk("reset_irq", err_irq, 0);

        // Single NONSEQ write
        drive(1'b1, 32'hDEAD_0000, HT_NONSEQ, 1'b1, 1'b1, 1'b0);
        bus("single_c0", 1'b1, 1'b0);
        idle(1'b0);
        bus("single_c1", 1'b0, 1'b1);
        chk("single_addr", err_addr, LOG_EN ? 32'hDEAD_0000 : 0);
        chk("single_write", err_write, LOG_EN ? 1 : 0);
        chk("single_cnt", err_cnt, LOG_EN ? 1 : 0);
        chk("single_irq", err_irq, LOG_EN ? 1 : 0);
        idle(1'b1);
        bus("single_c2", 1'b1, 1'b1);
        idle(1'b1);
        bus("single_c3", 1'b1, 1'b0);

        // Clear alone
        drive(1'b0, 32'h0, HT_IDLE, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        chk("clr_cnt", err_cnt, 0);
        chk("clr_irq", err_irq, 0);

        // Back-to-back errors
        drive(1'b1, 32'h0000_1000, HT_NONSEQ, 1'b0, 1'b1, 1'b0);
        bus("b2b_0", 1'b1, 1'b0);
        idle(1'b0);
        bus("b2b_err1a", 1'b0, 1'b1);
        drive(1'b1, 32'h0000_2000, HT_SEQ, 1'b1, 1'b1, 1'b0);
        bus("b2b_err2a", 1'b1, 1'b1);
        idle(1'b0);
        bus("b2b_err1b", 1'b0, 1'b1);
        drive(1'b1, 32'h0000_3000, HT_NONSEQ, 1'b0, 1'b1, 1'b0);
        bus("b2b_err2b", 1'b1, 1'b1);
        idle(1'b0);
        bus("b2b_err1c", 1'b0, 1'b1);
        idle(1'b1);
        bus("b2b_err2c", 1'b1, 1'b1);
        idle(1'b1);
        bus("b2b_done", 1'b1, 1'b0);
        chk("b2b_cnt", err_cnt, LOG_EN ? 3 : 0);
        chk("b2b_addr", err_addr, LOG_EN ? 32'h0000_3000 : 0);

        // IDLE/BUSY with hsel high get zero-wait OKAY
        drive(1'b0, 32'h0, HT_IDLE, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h4000 + i, (i % 2) ? HT_BUSY : HT_IDLE, 1'b1, 1'b1, 1'b0);
            bus("idlebusy", 1'b1, 1'b0);
        end
        idle(1'b1);
        chk("idlebusy_cnt", err_cnt, 0);

        // Address phase held off by hready low
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h0000_5000, HT_NONSEQ, 1'b1, 1'b0, 1'b0);
            bus("hold", 1'b1, 1'b0);
        end
        drive(1'b1, 32'h0000_5000, HT_NONSEQ, 1'b1, 1'b1, 1'b0);
        bus("hold_rise", 1'b1, 1'b0);
        idle(1'b0);
        bus("hold_err1", 1'b0, 1'b1);
        idle(1'b1);
        bus("hold_err2", 1'b1, 1'b1);
        idle(1'b1);
        bus("hold_done", 1'b1, 1'b0);
        chk("hold_cnt", err_cnt, LOG_EN ? 1 : 0);

        // Reset during ERR1
        drive(1'b1, 32'h0000_6000, HT_NONSEQ, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        bus("rst_pre", 1'b0, 1'b1);
        #1 rst = 1'b1;
        #1;
        bus("rst_mid", 1'b1, 1'b0);
        chk("rst_mid_cnt", err_cnt, 0);
        idle(1'b1);
        rst = 1'b0;
        drive(1'b1, 32'h0000_7000, HT_NONSEQ, 1'b1, 1'b1, 1'b0);
        bus("restart_0", 1'b1, 1'b0);
        idle(1'b0);
        bus("restart_err1", 1'b0, 1'b1);
        idle(1'b1);
        bus("restart_err2", 1'b1, 1'b1);
        idle(1'b1);
        bus("restart_done", 1'b1, 1'b0);

        // Counter saturation
        drive(1'b0, 32'h0, HT_IDLE, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h8000 + i, HT_NONSEQ, 1'b0, 1'b1, 1'b0);
            idle(1'b0);
            idle(1'b1);
        end
        idle(1'b1);
        chk("sat_cnt", err_cnt, LOG_EN ? 3 : 0);

        // Clear alone, then clear coinciding with an accept
        drive(1'b0, 32'h0, HT_IDLE, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        chk("clr2_cnt", err_cnt, 0);
        chk("clr2_irq", err_irq, 0);
        drive(1'b1, 32'h0000_9000, HT_NONSEQ, 1'b1, 1'b1, 1'b1);
        idle(1'b0);
        chk("clracc_cnt", err_cnt, LOG_EN ? 1 : 0);
        chk("clracc_irq", err_irq, LOG_EN ? 1 : 0);
        chk("clracc_addr", err_addr, LOG_EN ? 32'h0000_9000 : 0);
        idle(1'b1);
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 399) == 0);
        end
        rst = 1'b0;
        idle(1'b1);
        idle(1'b1);
        @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
